// File: rtl/core_seq.sv
// core_seq: multi-cycle fetch/decode/execute/memory/write-back sequencer for the RV32I core.
// All control outputs are flops updated together with the state register.
module core_seq #(
   parameter logic [31:0] BOOT_PC  = 32'h0000_0000,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   input  logic        illegal,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        wb_en,
   input  logic [31:0] next_pc,
   output logic [31:0] pc,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_we,
   output logic        retire,
   output logic [31:0] instret,
   output logic        fault,
   output logic [1:0]  fault_cause
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;

   // Fetch address is the architectural PC.
   assign imem_addr = pc;

   // Sequencer: state, wait counter, PC/IR/instret and all registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         pc          <= BOOT_PC;
         ir          <= NOP;
         instret     <= '0;
         imem_req    <= 1'b0;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         rf_we       <= 1'b0;
         retire      <= 1'b0;
         fault       <= 1'b0;
         fault_cause <= 2'b00;
      end else begin
         rf_we  <= 1'b0;
         retire <= 1'b0;
         case (state)
            S_IDLE: begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
               wait_cnt <= '0;
            end
            S_FETCH: begin
               // An ack in the last allowed cycle still wins over the timeout.
               if (imem_ack) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end else if (wait_cnt == WAIT_LAST) begin
                  imem_req    <= 1'b0;
                  fault       <= 1'b1;
                  fault_cause <= 2'b10;
                  state       <= S_FAULT;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_DECODE: begin
               if (illegal) begin
                  fault       <= 1'b1;
                  fault_cause <= 2'b01;
                  state       <= S_FAULT;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_load || is_store) begin
                  dmem_req <= 1'b1;
                  dmem_we  <= is_store;
                  wait_cnt <= '0;
                  state    <= S_MEM;
               end else begin
                  rf_we  <= wb_en;
                  retire <= 1'b1;
                  state  <= S_WB;
               end
            end
            S_MEM: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  rf_we    <= wb_en;
                  retire   <= 1'b1;
                  state    <= S_WB;
               end else if (wait_cnt == WAIT_LAST) begin
                  dmem_req    <= 1'b0;
                  dmem_we     <= 1'b0;
                  fault       <= 1'b1;
                  fault_cause <= 2'b11;
                  state       <= S_FAULT;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_WB: begin
               pc       <= next_pc;
               instret  <= instret + 32'd1;
               imem_req <= 1'b1;
               wait_cnt <= '0;
               state    <= S_FETCH;
            end
            S_FAULT: begin
               state <= S_FAULT;
            end
            default: begin
               imem_req <= 1'b0;
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
               fault    <= 1'b1;
               state    <= S_FAULT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: drives core_seq as instruction memory, decoder, datapath and data memory,
// and checks each instruction's timing and architectural effects against a per-instruction model.
module tb_core_seq;

   localparam logic [31:0] BOOT = 32'h0000_0100;
   localparam int unsigned MAXW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, rf_we, retire, fault;
   logic        illegal, is_load, is_store, wb_en;
   logic [31:0] imem_addr, imem_rdata, ir, next_pc, pc, instret;
   logic [1:0]  fault_cause;
   logic [6:0]  opc;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_pc;
   logic [31:0] m_instret;

   core_seq #(.BOOT_PC(BOOT), .MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir(ir), .illegal(illegal), .is_load(is_load), .is_store(is_store), .wb_en(wb_en),
      .next_pc(next_pc), .pc(pc),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .retire(retire), .instret(instret),
      .fault(fault), .fault_cause(fault_cause)
   );

   always #5 clk = ~clk;

   // Environment decoder/datapath; opcode 0x2F is a test-only "load and store" pattern.
   always_comb begin
      opc      = ir[6:0];
      is_load  = (opc == 7'h03) || (opc == 7'h2F);
      is_store = (opc == 7'h23) || (opc == 7'h2F);
      wb_en    = (opc != 7'h23);
      illegal  = !(opc inside {7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h6F, 7'h2F});
      next_pc  = (opc == 7'h6F) ? {ir[31:12], 12'h000} : pc + 32'd4;
   end

   typedef struct {
      logic [31:0] w;
      int          fw;
      int          dw;
      int          exp_k;
      logic        exp_rf;
      logic        exp_we;
      int          exp_dcyc;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w);
      logic [6:0] o;
      o = w[6:0];
      return (o == 7'h6F) ? {w[31:12], 12'h000} : p + 32'd4;
   endfunction

   task automatic wait_fetch(input string name);
      int n;
      n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(imem_req), 32'd1);
   endtask

   // One instruction from FETCH entry (k=0) to the following FETCH cycle.
   task automatic run_instr(input logic [31:0] w, input int fw, input int dw, input int exp_k,
                            input logic exp_rf, input logic exp_we, input int exp_dcyc);
      int   k, fcnt, dcnt, ret_k, we_bad, stray;
      logic rf_at;
      bit   done;
      wait_fetch("fetch_start");
      chk("imem_addr", imem_addr, m_pc);
      chk("instret_pre", instret, m_instret);
      k = 0; fcnt = 0; dcnt = 0; ret_k = -1; we_bad = 0; stray = 0; rf_at = 1'b0; done = 0;
      imem_rdata = w;
      while (!done && k < 40) begin
         if (imem_req) begin
            imem_ack = (fcnt == fw);
            fcnt++;
         end else begin
            imem_ack = 1'($urandom_range(0, 1));
         end
         if (dmem_req) begin
            if (dmem_we !== exp_we) we_bad++;
            dmem_ack = (dcnt == dw);
            dcnt++;
         end else begin
            dmem_ack = 1'($urandom_range(0, 1));
         end
         if (retire) begin
            ret_k = k;
            rf_at = rf_we;
            done  = 1;
         end else if (rf_we) begin
            stray++;
         end
         @(negedge clk);
         k++;
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      chk("retire_cycle", 32'(ret_k), 32'(exp_k));
      chk("rf_we_at_retire", 32'(rf_at), 32'(exp_rf));
      chk("rf_we_stray", 32'(stray), 32'd0);
      chk("dmem_cycles", 32'(dcnt), 32'(exp_dcyc));
      chk("dmem_we", 32'(we_bad), 32'd0);
      chk("ir", ir, w);
      chk("retire_pulse", 32'(retire), 32'd0);
      m_pc      = model_next(m_pc, w);
      m_instret = m_instret + 32'd1;
      chk("pc_next", pc, m_pc);
   endtask

   task automatic do_reset();
      int n;
      @(negedge clk);
      rst_n    = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      #1;
      chk("rst_pc", pc, BOOT);
      chk("rst_ir", ir, 32'h0000_0013);
      chk("rst_strobes", {27'd0, imem_req, dmem_req, dmem_we, rf_we, retire}, 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_fault", {29'd0, fault, fault_cause}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("startup_idle", 32'(imem_req), 32'd0);
      n = 0;
      while (!imem_req && n < 6) begin
         @(negedge clk);
         n++;
      end
      chk("startup_edges", 32'(n >= 1 && n <= 2), 32'd1);
      m_pc      = BOOT;
      m_instret = 32'd0;
   endtask

   function automatic int lat(input int fw, input int dw, input bit mem);
      return 3 + fw + (mem ? dw + 1 : 0);
   endfunction

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      logic [6:0]  opcs[7];
      logic [31:0] r, w;
      int          fw, dw, bad;
      bit          mem;
      int          n;

      opcs = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h37, 7'h6F, 7'h2F};
      imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'd0;

      tbl[0] = '{32'h0010_8093, 0, 0, 3, 1'b1, 1'b0, 0};   // addi
      tbl[1] = '{32'h0010_8093, 0, 0, 3, 1'b1, 1'b0, 0};
      tbl[2] = '{32'h0010_8093, 0, 0, 3, 1'b1, 1'b0, 0};
      tbl[3] = '{32'h0000_A103, 0, 3, 7, 1'b1, 1'b0, 4};   // lw, ack after 3 waits
      tbl[4] = '{32'h0020_A023, 0, 0, 4, 1'b0, 1'b1, 1};   // sw
      tbl[5] = '{32'h0000_002F, 1, 2, 7, 1'b1, 1'b1, 3};   // load+store: store wins
      tbl[6] = '{32'h0020_81B3, 3, 0, 6, 1'b1, 1'b0, 0};   // add, fetch ack in last allowed cycle
      tbl[7] = '{32'h0040_006F, 0, 0, 3, 1'b1, 1'b0, 0};   // jal -> 0x0040_0000
      tbl[8] = '{32'h1234_52B7, 2, 0, 5, 1'b1, 1'b0, 0};   // lui
      tbl[9] = '{32'h0000_A103, 3, 3, 10, 1'b1, 1'b0, 4};  // lw, both waits at the limit

      do_reset();

      for (int i = 0; i < 10; i++) begin
         run_instr(tbl[i].w, tbl[i].fw, tbl[i].dw, tbl[i].exp_k,
                   tbl[i].exp_rf, tbl[i].exp_we, tbl[i].exp_dcyc);
         if (i == 2) chk("instret_after_3", instret, 32'd3);
      end

      // instret wrap
      force dut.instret = 32'hFFFF_FFFF;
      #1;
      release dut.instret;
      m_instret = 32'hFFFF_FFFF;
      run_instr(32'h0010_8093, 0, 0, 3, 1'b1, 1'b0, 0);
      chk("instret_wrap", instret, 32'd0);

      // randomized instruction stream
      for (int i = 0; i < 40; i++) begin
         r   = $urandom();
         w   = {r[31:7], opcs[$urandom_range(0, 6)]};
         fw  = $urandom_range(0, 3);
         dw  = $urandom_range(0, 3);
         mem = (w[6:0] == 7'h03) || (w[6:0] == 7'h23) || (w[6:0] == 7'h2F);
         run_instr(w, fw, dw, lat(fw, dw, mem), 1'(w[6:0] != 7'h23),
                   1'((w[6:0] == 7'h23) || (w[6:0] == 7'h2F)), mem ? dw + 1 : 0);
      end

      // fetch timeout: no ack ever
      wait_fetch("to_fetch_start");
      imem_ack = 1'b0;
      n = 0;
      while (imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("fetch_to_cycles", 32'(n), 32'(MAXW));
      chk("fetch_to_fault", {29'd0, fault, fault_cause}, 32'b110);
      chk("fetch_to_instret", instret, m_instret);
      chk("fetch_to_pc", pc, m_pc);

      // illegal opcode, then held fault for 100 cycles
      do_reset();
      run_instr(32'h0010_8093, 0, 0, 3, 1'b1, 1'b0, 0);
      wait_fetch("ill_fetch_start");
      imem_rdata = 32'h0000_007F;
      imem_ack   = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (!fault || fault_cause != 2'b01 || retire || rf_we || imem_req || dmem_req) bad++;
         imem_ack = 1'($urandom_range(0, 1));
         dmem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      chk("ill_cause", 32'(fault_cause), 32'd1);
      chk("ill_held", 32'(bad), 32'd0);
      chk("ill_pc", pc, m_pc);
      chk("ill_instret", instret, m_instret);
      rst_n = 1'b0;
      #1;
      chk("ill_rst_pc", pc, BOOT);
      chk("ill_rst_fault", 32'(fault), 32'd0);

      // data timeout
      do_reset();
      wait_fetch("dto_fetch_start");
      imem_rdata = 32'h0000_A103;
      imem_ack   = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      n = 0; bad = 0;
      for (int i = 0; i < 12 && !fault; i++) begin
         if (dmem_req) n++;
         if (retire) bad++;
         @(negedge clk);
      end
      chk("data_to_cycles", 32'(n), 32'(MAXW));
      chk("data_to_fault", {29'd0, fault, fault_cause}, 32'b111);
      chk("data_to_req", 32'(dmem_req), 32'd0);
      chk("data_to_no_retire", 32'(bad), 32'd0);

      // reset asserted in the middle of MEM
      do_reset();
      wait_fetch("mr_fetch_start");
      imem_rdata = 32'h0000_A103;
      imem_ack   = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      n = 0;
      while (n < 2 && !fault) begin
         if (dmem_req) n++;
         if (n < 2) @(negedge clk);
      end
      chk("mr_in_mem", 32'(dmem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_async_drop", 32'(dmem_req), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0; n = 0;
      while (!imem_req && n < 6) begin
         if (dmem_req || rf_we || retire) bad++;
         @(negedge clk);
         n++;
      end
      chk("mr_quiet", 32'(bad), 32'd0);
      chk("mr_refetch", {imem_req, imem_addr[30:0]}, {1'b1, BOOT[30:0]});
      chk("mr_instret", instret, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
